// File: rtl/async_fifo_wr_arb_pkg.sv
// rtl/async_fifo_wr_arb_pkg.sv - shared types and sizing helpers for the async FIFO write arbiter
package async_fifo_wr_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int STAT_W = 16;

    // FIFO word width as seen by the read side when unpacking {id, last, data}
    function automatic int fifo_word_w(input int dw, input int n);
        return dw + $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/async_fifo_arb_rr_pick.sv
// rtl/async_fifo_arb_rr_pick.sv - combinational rotate-priority encoder, first req above ptr wins
module async_fifo_arb_rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           any,
    output logic [IDW-1:0] idx
);

    int j;

    // Scan from farthest to nearest so the closest candidate above ptr is written last
    always_comb begin
        idx = '0;
        j   = 0;
        for (int k = N; k >= 1; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                idx = IDW'(j);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/async_fifo_wr_arb.sv
// rtl/async_fifo_wr_arb.sv - packet-atomic round-robin arbiter for an async FIFO write port
// Optional counters behind ASYNC_FIFO_WR_ARB_STATS_EN.
module async_fifo_wr_arb
    import async_fifo_wr_arb_pkg::*;
#(
    parameter  int N   = 4,
    parameter  int DW  = 32,
    localparam int IDW = (N > 1) ? $clog2(N) : 1,
    localparam int FW  = DW + IDW + 1
) (
    input  logic            wclk,
    input  logic            wrst_n,
    input  logic [N-1:0]    req_valid,
    input  logic [N*DW-1:0] req_data,
    input  logic [N-1:0]    req_last,
    output logic [N-1:0]    req_ready,
    output logic            fifo_wr_en,
    output logic [FW-1:0]   fifo_wr_data,
    input  logic            fifo_wr_full,
    output logic            busy,
    output logic [IDW-1:0]  grant_id
`ifdef ASYNC_FIFO_WR_ARB_STATS_EN
    ,
    input  logic                stat_clr,
    output logic [N*STAT_W-1:0] stat_pkts,
    output logic [STAT_W-1:0]   stat_stall
`endif
);

    arb_state_t     state;
    logic [IDW-1:0] rr_ptr;
    logic           pick_any;
    logic [IDW-1:0] pick_idx;
    logic           g_valid;
    logic           g_last;
    logic [DW-1:0]  g_data;
    logic           accept;

    async_fifo_arb_rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Explicit mux keeps the data path X-free even for grant_id values >= N
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_id == IDW'(i)) begin
                g_valid = req_valid[i];
                g_last  = req_last[i];
                g_data  = req_data[i*DW +: DW];
            end
        end
    end

    assign busy = (state == GRANT);

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N; i++) begin
            req_ready[i] = busy && (grant_id == IDW'(i)) && !fifo_wr_full;
        end
    end

    assign accept       = busy && g_valid && !fifo_wr_full;
    assign fifo_wr_en   = accept;
    assign fifo_wr_data = {grant_id, g_last, g_data};

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state    <= IDLE;
            rr_ptr   <= IDW'(N - 1);
            grant_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant_id <= pick_idx;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (accept && g_last) begin
                        rr_ptr <= grant_id;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ASYNC_FIFO_WR_ARB_STATS_EN
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            stat_pkts  <= '0;
            stat_stall <= '0;
        end else if (stat_clr) begin
            stat_pkts  <= '0;
            stat_stall <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (accept && g_last && (grant_id == IDW'(i)) &&
                    (stat_pkts[i*STAT_W +: STAT_W] != {STAT_W{1'b1}})) begin
                    stat_pkts[i*STAT_W +: STAT_W] <= stat_pkts[i*STAT_W +: STAT_W] + STAT_W'(1);
                end
            end
            if (busy && g_valid && fifo_wr_full && (stat_stall != {STAT_W{1'b1}})) begin
                stat_stall <= stat_stall + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_async_fifo_wr_arb.sv
// tb/tb_async_fifo_wr_arb.sv - vector table, corner sequences and random model check for the write arbiter
module tb_async_fifo_wr_arb;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int FW = 35;

    logic            wclk = 1'b0;
    logic            wrst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_last = '0;
    logic [N-1:0]    req_ready;
    logic            fifo_wr_en;
    logic [FW-1:0]   fifo_wr_data;
    logic            fifo_wr_full = 1'b0;
    logic            busy;
    logic [1:0]      grant_id;
`ifdef ASYNC_FIFO_WR_ARB_STATS_EN
    logic            stat_clr = 1'b0;
    logic [N*16-1:0] stat_pkts;
    logic [15:0]     stat_stall;
`endif
    logic            clr_req = 1'b0;

    int n_checks = 0;
    int n_err = 0;

    always #5 wclk = ~wclk;

    async_fifo_wr_arb #(.N(N), .DW(DW)) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_wr_full (fifo_wr_full),
        .busy         (busy),
        .grant_id     (grant_id)
`ifdef ASYNC_FIFO_WR_ARB_STATS_EN
        ,
        .stat_clr     (stat_clr),
        .stat_pkts    (stat_pkts),
        .stat_stall   (stat_stall)
`endif
    );

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [3:0]  last;
        logic        full;
        logic [31:0] d;
        logic        e_busy;
        logic [1:0]  e_gid;
        logic        e_wen;
        logic [3:0]  e_rdy;
        logic [34:0] e_wdata;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [34:0] mkw(input int g, input logic l, input logic [31:0] d);
        logic [1:0] gg;
        gg = 2'(g);
        return {gg, l, d};
    endfunction

    function automatic void add(input logic r, input logic [3:0] v, input logic [3:0] l, input logic f,
                                input logic [31:0] d, input logic eb, input int eg, input logic ew,
                                input logic [3:0] er, input logic [34:0] ed);
        vec_t x;
        x.rst = r; x.valid = v; x.last = l; x.full = f; x.d = d;
        x.e_busy = eb; x.e_gid = 2'(eg); x.e_wen = ew; x.e_rdy = er; x.e_wdata = ed;
        vecs.push_back(x);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1ns after the active edge; outputs are sampled on the falling edge
    task automatic drive(input logic r, input logic [3:0] v, input logic [3:0] l, input logic f,
                         input logic [31:0] d);
        @(posedge wclk);
        #1;
        wrst_n       = !r;
        req_valid    = v;
        req_last     = l;
        fifo_wr_full = f;
        req_data     = {N{d}};
`ifdef ASYNC_FIFO_WR_ARB_STATS_EN
        stat_clr     = clr_req;
`endif
        @(negedge wclk);
    endtask

    task automatic do_reset();
        drive(1'b1, 4'b0000, 4'b0000, 1'b0, 32'h0);
    endtask

    int m_busy, m_g, m_ptr, open_id;
    logic [3:0]  e_rdy;
    logic        e_wen;
    logic [34:0] e_wd;

    initial begin
        // Reset, then a 3-beat packet from requester 2
        add(1, 4'b0000, 4'b0000, 0, 32'h0,  0, 0, 0, 4'b0000, '0);
        add(0, 4'b0100, 4'b0000, 0, 32'hA1, 0, 0, 0, 4'b0000, '0);
        add(0, 4'b0100, 4'b0000, 0, 32'hA1, 1, 2, 1, 4'b0100, mkw(2, 0, 32'hA1));
        add(0, 4'b0100, 4'b0000, 0, 32'hA2, 1, 2, 1, 4'b0100, mkw(2, 0, 32'hA2));
        add(0, 4'b0100, 4'b0100, 0, 32'hA3, 1, 2, 1, 4'b0100, mkw(2, 1, 32'hA3));
        add(0, 4'b0000, 4'b0000, 0, 32'h0,  0, 0, 0, 4'b0000, '0);
        // All four requesters with back-to-back single-beat packets
        add(1, 4'b0000, 4'b0000, 0, 32'h0,  0, 0, 0, 4'b0000, '0);
        for (int k = 0; k < 6; k++) begin
            add(0, 4'b1111, 4'b1111, 0, 32'h100 + k, 0, 0, 0, 4'b0000, '0);
            add(0, 4'b1111, 4'b1111, 0, 32'h100 + k, 1, k % 4, 1, 4'(1 << (k % 4)),
                mkw(k % 4, 1, 32'h100 + k));
        end

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].valid, vecs[i].last, vecs[i].full, vecs[i].d);
            chk($sformatf("vec%0d busy", i), 64'(busy), 64'(vecs[i].e_busy));
            chk($sformatf("vec%0d wr_en", i), 64'(fifo_wr_en), 64'(vecs[i].e_wen));
            chk($sformatf("vec%0d ready", i), 64'(req_ready), 64'(vecs[i].e_rdy));
            if (vecs[i].e_busy) chk($sformatf("vec%0d grant_id", i), 64'(grant_id), 64'(vecs[i].e_gid));
            if (vecs[i].e_wen) chk($sformatf("vec%0d wr_data", i), 64'(fifo_wr_data), 64'(vecs[i].e_wdata));
        end

        // FIFO full for 5 cycles in the middle of a 4-beat packet from requester 1
        do_reset();
        drive(0, 4'b0010, 4'b0000, 0, 32'hB1);
        chk("stall idle busy", 64'(busy), 64'd0);
        drive(0, 4'b0010, 4'b0000, 0, 32'hB1);
        chk("stall beat1", 64'({fifo_wr_en, fifo_wr_data}), 64'({1'b1, mkw(1, 0, 32'hB1)}));
        drive(0, 4'b0010, 4'b0000, 0, 32'hB2);
        chk("stall beat2", 64'({fifo_wr_en, fifo_wr_data}), 64'({1'b1, mkw(1, 0, 32'hB2)}));
        for (int c = 0; c < 5; c++) begin
            drive(0, 4'b0010, 4'b0000, 1, 32'hB3);
            chk($sformatf("stall c%0d ready", c), 64'(req_ready), 64'd0);
            chk($sformatf("stall c%0d wr_en", c), 64'(fifo_wr_en), 64'd0);
            chk($sformatf("stall c%0d busy", c), 64'({busy, grant_id}), 64'({1'b1, 2'd1}));
        end
        drive(0, 4'b0010, 4'b0000, 0, 32'hB3);
        chk("stall beat3", 64'({fifo_wr_en, fifo_wr_data}), 64'({1'b1, mkw(1, 0, 32'hB3)}));
        drive(0, 4'b0010, 4'b0010, 0, 32'hB4);
        chk("stall beat4", 64'({fifo_wr_en, fifo_wr_data}), 64'({1'b1, mkw(1, 1, 32'hB4)}));
        drive(0, 4'b0000, 4'b0000, 0, 32'h0);
        chk("stall end idle", 64'({busy, fifo_wr_en}), 64'd0);

        // Grantee 0 drops valid mid-packet while requester 3 waits
        do_reset();
        drive(0, 4'b1001, 4'b0000, 0, 32'hC1);
        chk("drop idle", 64'(busy), 64'd0);
        drive(0, 4'b1001, 4'b0000, 0, 32'hC1);
        chk("drop beat1", 64'({busy, grant_id, fifo_wr_en}), 64'({1'b1, 2'd0, 1'b1}));
        for (int c = 0; c < 3; c++) begin
            drive(0, 4'b1000, 4'b0000, 0, 32'hC2);
            chk($sformatf("drop hold%0d", c), 64'({busy, grant_id, fifo_wr_en, req_ready}),
                64'({1'b1, 2'd0, 1'b0, 4'b0001}));
        end
        drive(0, 4'b1001, 4'b0001, 0, 32'hC2);
        chk("drop last", 64'({fifo_wr_en, fifo_wr_data}), 64'({1'b1, mkw(0, 1, 32'hC2)}));
        drive(0, 4'b1000, 4'b0000, 0, 32'h0);
        chk("drop bubble", 64'(busy), 64'd0);
        drive(0, 4'b1000, 4'b0000, 0, 32'h0);
        chk("drop next grant", 64'({busy, grant_id}), 64'({1'b1, 2'd3}));

        // Asynchronous reset during beat 2
        do_reset();
        drive(0, 4'b0010, 4'b0000, 0, 32'hD1);
        drive(0, 4'b0010, 4'b0000, 0, 32'hD1);
        drive(0, 4'b0010, 4'b0000, 0, 32'hD2);
        chk("rst beat2 active", 64'({busy, fifo_wr_en}), 64'({1'b1, 1'b1}));
        wrst_n = 1'b0;
        #1;
        chk("rst async busy", 64'(busy), 64'd0);
        chk("rst async ready", 64'({req_ready, fifo_wr_en}), 64'd0);
        drive(1, 4'b1111, 4'b1111, 0, 32'h0);
        drive(0, 4'b1111, 4'b1111, 0, 32'hE0);
        chk("rst release idle", 64'(busy), 64'd0);
        drive(0, 4'b1111, 4'b1111, 0, 32'hE0);
        chk("rst first winner", 64'({busy, grant_id}), 64'({1'b1, 2'd0}));

        // Random traffic against a transaction-level reference model
        do_reset();
        m_busy = 0; m_g = 0; m_ptr = N - 1; open_id = -1;
        for (int c = 0; c < 400; c++) begin
            @(posedge wclk);
            #1;
            wrst_n       = 1'b1;
            req_valid    = 4'($urandom);
            req_last     = 4'($urandom);
            fifo_wr_full = ($urandom_range(0, 4) == 0);
            for (int i = 0; i < N; i++) req_data[i*DW +: DW] = $urandom;
            @(negedge wclk);
            e_rdy = (m_busy != 0 && !fifo_wr_full) ? 4'(1 << m_g) : 4'b0000;
            e_wen = (m_busy != 0) && req_valid[m_g] && !fifo_wr_full;
            e_wd  = mkw(m_g, req_last[m_g], req_data[m_g*DW +: DW]);
            chk($sformatf("rnd%0d busy", c), 64'(busy), 64'(m_busy != 0));
            chk($sformatf("rnd%0d ready", c), 64'(req_ready), 64'(e_rdy));
            chk($sformatf("rnd%0d wr_en", c), 64'(fifo_wr_en), 64'(e_wen));
            if (m_busy != 0) chk($sformatf("rnd%0d grant_id", c), 64'(grant_id), 64'(m_g));
            if (e_wen) chk($sformatf("rnd%0d wr_data", c), 64'(fifo_wr_data), 64'(e_wd));
            // Packets from different sources must never interleave in the FIFO stream
            if (fifo_wr_en) begin
                if (open_id >= 0) chk($sformatf("rnd%0d interleave", c), 64'(fifo_wr_data[34:33]), 64'(open_id));
                open_id = fifo_wr_data[32] ? -1 : int'(fifo_wr_data[34:33]);
            end
            if (m_busy == 0) begin
                for (int k = 1; k <= N; k++) begin
                    if (req_valid[(m_ptr + k) % N]) begin
                        m_g = (m_ptr + k) % N;
                        m_busy = 1;
                        break;
                    end
                end
            end else if (e_wen && req_last[m_g]) begin
                m_busy = 0;
                m_ptr = m_g;
            end
        end

`ifdef ASYNC_FIFO_WR_ARB_STATS_EN
        do_reset();
        for (int p = 0; p < 5; p++) begin
            drive(0, 4'b0100, 4'b0100, 0, 32'(p));
            drive(0, 4'b0100, 4'b0100, 0, 32'(p));
        end
        drive(0, 4'b0100, 4'b0100, 0, 32'h6);
        chk("stat pkts2", 64'(stat_pkts[2*16 +: 16]), 64'd5);
        chk("stat others", 64'({stat_pkts[3*16 +: 16], stat_pkts[1*16 +: 16], stat_pkts[0 +: 16]}), 64'd0);
        clr_req = 1'b1;
        drive(0, 4'b0100, 4'b0100, 0, 32'h6);
        chk("stat 6th beat", 64'(fifo_wr_en), 64'd1);
        clr_req = 1'b0;
        drive(0, 4'b0000, 4'b0000, 0, 32'h0);
        chk("stat clr wins", 64'(stat_pkts[2*16 +: 16]), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
